// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: FIFO-side handshake, data and threshold bundle of fifo_rr_arbiter.
// The master modport is the arbiter; the slave modport is the FIFO side.
interface fifo_rr_arbiter_if #(
  parameter int WORD_SIZE = 10,
  parameter int PTR = 3
);
  logic [3:0] fifo_empty;
  logic [4*WORD_SIZE-1:0] data_in;
  logic out_almost_full;
  logic out_full;
  logic [PTR-1:0] cfg_full_thr;
  logic [PTR-1:0] cfg_empty_thr;
  logic cfg_load;
  logic [3:0] fifo_rd;
  logic fifo_wr;
  logic [WORD_SIZE-1:0] data_out;
  logic [PTR-1:0] full_threshold;
  logic [PTR-1:0] empty_threshold;
  logic error;
  logic [1:0] state;
  modport master (
    input fifo_empty, data_in, out_almost_full, out_full, cfg_full_thr, cfg_empty_thr, cfg_load,
    output fifo_rd, fifo_wr, data_out, full_threshold, empty_threshold, error, state
  );
  modport slave (
    output fifo_empty, data_in, out_almost_full, out_full, cfg_full_thr, cfg_empty_thr, cfg_load,
    input fifo_rd, fifo_wr, data_out, full_threshold, empty_threshold, error, state
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: merges four input FIFOs into one downstream FIFO through a read/write pipeline.
// Define STRICT_PRIO_EN for fixed priority (channel 0 highest) instead of round-robin.
module fifo_rr_arbiter #(
  parameter int WORD_SIZE = 10,
  parameter int PTR = 3
) (
  input logic clk,
  input logic reset,
  fifo_rr_arbiter_if.master bus
);
  localparam logic [1:0] INIT = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2, ERROR = 2'd3;
  logic [1:0] state, next_state, grant, base, rd_ch;
  logic [3:0] req, fifo_rd;
  logic rd_vld, wr_due, drop, issue, fifo_wr, error;
  logic [WORD_SIZE-1:0] data_out;
  logic [PTR-1:0] full_thr, empty_thr;
  assign req = ~bus.fifo_empty;
  assign wr_due = rd_vld && state != ERROR;
  assign drop = wr_due && bus.out_full;
  assign issue = state == ACTIVE && |req && !bus.out_almost_full && !drop;
  assign next_state = drop ? ERROR :
                      state == INIT ? IDLE :
                      state == IDLE ? (bus.cfg_load ? INIT : |req ? ACTIVE : IDLE) :
                      state == ACTIVE ? (|req ? ACTIVE : IDLE) : ERROR;
`ifdef STRICT_PRIO_EN
  assign base = 2'd3;
`else
  logic [1:0] last_grant;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_grant <= 2'd3;
    else if (issue) last_grant <= grant;
  assign base = last_grant;
`endif
  // Search order is base+1, base+2, ... so the lowest offset that requests wins.
  always_comb begin
    grant = base + 2'd1;
    for (int k = 3; k >= 0; k--)
      if (req[base + 2'(k) + 2'd1]) grant = base + 2'(k) + 2'd1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      fifo_rd <= 4'b0000;
      fifo_wr <= 1'b0;
      data_out <= '0;
      error <= 1'b0;
      full_thr <= '0;
      empty_thr <= '0;
      rd_vld <= 1'b0;
      rd_ch <= 2'd0;
    end else begin
      state <= next_state;
      fifo_rd <= issue ? 4'b0001 << grant : 4'b0000;
      rd_vld <= |fifo_rd;
      rd_ch <= {fifo_rd[3] | fifo_rd[2], fifo_rd[3] | fifo_rd[1]};
      fifo_wr <= wr_due && !bus.out_full;
      if (wr_due && !bus.out_full) data_out <= bus.data_in[int'(rd_ch) * WORD_SIZE +: WORD_SIZE];
      if (drop) error <= 1'b1;
      if (state == INIT) begin
        full_thr <= bus.cfg_full_thr;
        empty_thr <= bus.cfg_empty_thr;
      end
    end
  assign bus.fifo_rd = fifo_rd;
  assign bus.fifo_wr = fifo_wr;
  assign bus.data_out = data_out;
  assign bus.full_threshold = full_thr;
  assign bus.empty_threshold = empty_thr;
  assign bus.error = error;
  assign bus.state = state;
endmodule
